// File: rtl/omem_pkg.sv
// Shared register map constants and the STATUS word layout for the output spike memory.
package omem_pkg;

  // STATUS and CTRL sit directly after the W spike words of each bank
  localparam int STATUS_OFS = 0;
  localparam int CTRL_OFS   = 1;

  localparam int CTRL_ACC   = 0;
  localparam int CTRL_COR   = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int CTRL_W     = 3;

  localparam int ST_FRESH   = 0;
  localparam int ST_OVR     = 1;
  localparam int ST_CNT_LSB = 16;
  localparam int ST_CNT_W   = 16;

  typedef struct packed {
    logic [ST_CNT_W-1:0] count;
    logic [13:0]         rsvd;
    logic                overrun;
    logic                fresh;
  } status_t;

endpackage

// File: rtl/omem_core_bank.sv
// One core's spike bank: W captured words plus fresh/overrun flags, capture counter and CTRL.
module omem_core_bank
  import omem_pkg::*;
#(
  parameter int NUM_NEURONS = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cap_i,
  input  logic [NUM_NEURONS-1:0] slice_i,
  input  logic                   acc_i,
  input  logic                   we_i,
  input  logic [3:0]             sel_i,
  input  logic [31:0]            idx_i,
  input  logic [31:0]            dat_i,
  output logic [31:0]            rdata_o,
  output logic                   fresh_o,
  output logic                   irq_en_o
);
  localparam int W = NUM_NEURONS / 32;

  logic [31:0]         words_q [W];
  logic [31:0]         words_d [W];
  logic                fresh_q, fresh_d;
  logic                ovr_q, ovr_d;
  logic [ST_CNT_W-1:0] cnt_q, cnt_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [31:0]         word_tmp;
  status_t             status;
  logic                rd, wr;

  assign rd       = acc_i & ~we_i;
  assign wr       = acc_i & we_i;
  assign fresh_o  = fresh_q;
  assign irq_en_o = ctrl_q[CTRL_IRQEN];

  always_comb begin
    status         = '0;
    status.fresh   = fresh_q;
    status.overrun = ovr_q;
    status.count   = cnt_q;
    rdata_o        = '0;
    for (int k = 0; k < W; k++)
      if (idx_i == 32'(k)) rdata_o = words_q[k];
    if (idx_i == 32'(W + STATUS_OFS)) rdata_o = status;
    if (idx_i == 32'(W + CTRL_OFS))   rdata_o = {{(32-CTRL_W){1'b0}}, ctrl_q};

    // Clear-on-read feeds into capture, so a read+capture leaves just the new slice
    word_tmp = '0;
    for (int k = 0; k < W; k++) begin
      word_tmp = words_q[k];
      if (rd && idx_i == 32'(k) && ctrl_q[CTRL_COR]) word_tmp = '0;
      if (cap_i) begin
        word_tmp = (ctrl_q[CTRL_ACC] ? word_tmp : 32'd0) | slice_i[NUM_NEURONS-1-32*k -: 32];
      end else if (wr && idx_i == 32'(k)) begin
        for (int b = 0; b < 4; b++)
          if (sel_i[b]) word_tmp[8*b +: 8] = dat_i[8*b +: 8];
      end
      words_d[k] = word_tmp;
    end

    fresh_d = fresh_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    if (wr && idx_i == 32'(W + STATUS_OFS) && sel_i[0]) begin
      if (dat_i[ST_FRESH]) fresh_d = 1'b0;
      if (dat_i[ST_OVR])   ovr_d   = 1'b0;
    end
    if (wr && idx_i == 32'(W + CTRL_OFS) && sel_i[0]) ctrl_d = dat_i[CTRL_W-1:0];
    // Capture overrides a same-cycle W1C; overrun looks at the flag before this cycle
    if (cap_i) begin
      ovr_d   = ovr_d | fresh_q;
      fresh_d = 1'b1;
      if (cnt_q != {ST_CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < W; k++) words_q[k] <= '0;
      fresh_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      for (int k = 0; k < W; k++) words_q[k] <= words_d[k];
      fresh_q <= fresh_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

endmodule

// File: rtl/omem_multi.sv
// Multi-core output spike memory: Wishbone decode, one-cycle ack, read mux and per-core irq.
module omem_multi
  import omem_pkg::*;
#(
  parameter int          NUM_CORES   = 2,
  parameter int          NUM_NEURONS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h80040000,
  parameter logic [31:0] CORE_STRIDE = 32'h00010000
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             wbs_cyc_i,
  input  logic                             wbs_stb_i,
  input  logic                             wbs_we_i,
  input  logic [3:0]                       wbs_sel_i,
  input  logic [31:0]                      wbs_adr_i,
  input  logic [31:0]                      wbs_dat_i,
  output logic                             wbs_ack_o,
  output logic [31:0]                      wbs_dat_o,
  input  logic [NUM_CORES-1:0]             enable_calc_i,
  input  logic [NUM_CORES*NUM_NEURONS-1:0] spike_neuron_i,
  output logic [NUM_CORES-1:0]             irq_o
);
  localparam int W = NUM_NEURONS / 32;

  logic [31:0]          off, core, idx, rd_mux;
  logic                 mapped, access;
  logic [31:0]          bank_rdata [NUM_CORES];
  logic [NUM_CORES-1:0] bank_fresh, bank_irq_en, bank_acc;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic [NUM_CORES-1:0] irq_q, irq_d;

  always_comb begin
    off    = wbs_adr_i - BASE_ADDR;
    core   = off / CORE_STRIDE;
    idx    = (off % CORE_STRIDE) >> 2;
    access = wbs_cyc_i & wbs_stb_i & ~ack_q;
    // Below-base addresses wrap to huge offsets, so the explicit compare is still needed
    mapped = (wbs_adr_i >= BASE_ADDR) && (core < 32'(NUM_CORES)) &&
             (idx < 32'(W + CTRL_OFS + 1));
    rd_mux = '0;
    for (int c = 0; c < NUM_CORES; c++)
      if (core == 32'(c)) rd_mux = bank_rdata[c];
    ack_d = access;
    dat_d = dat_q;
    if (access) dat_d = mapped ? rd_mux : 32'd0;
    irq_d = bank_fresh & bank_irq_en;
  end

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_bank
    assign bank_acc[gi] = access & mapped & (core == 32'(gi));

    omem_core_bank #(
      .NUM_NEURONS(NUM_NEURONS)
    ) u_bank (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .cap_i    (enable_calc_i[gi]),
      .slice_i  (spike_neuron_i[gi*NUM_NEURONS +: NUM_NEURONS]),
      .acc_i    (bank_acc[gi]),
      .we_i     (wbs_we_i),
      .sel_i    (wbs_sel_i),
      .idx_i    (idx),
      .dat_i    (wbs_dat_i),
      .rdata_o  (bank_rdata[gi]),
      .fresh_o  (bank_fresh[gi]),
      .irq_en_o (bank_irq_en[gi])
    );
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      irq_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      irq_q <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_omem_multi.sv
// Scoreboard bench for omem_multi: directed register-map checks followed by random traffic.
module tb_omem_multi;
  localparam int          NC     = 2;
  localparam int          NN     = 256;
  localparam int          W      = NN / 32;
  localparam logic [31:0] BASE   = 32'h80040000;
  localparam logic [31:0] STRIDE = 32'h00010000;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic             wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]       wbs_sel_i;
  logic [31:0]      wbs_adr_i, wbs_dat_i;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;
  logic [NC-1:0]    enable_calc_i;
  logic [NC*NN-1:0] spike_neuron_i;
  logic [NC-1:0]    irq_o;

  always #5 wb_clk_i = ~wb_clk_i;

  omem_multi #(
    .NUM_CORES(NC), .NUM_NEURONS(NN), .BASE_ADDR(BASE), .CORE_STRIDE(STRIDE)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .enable_calc_i(enable_calc_i), .spike_neuron_i(spike_neuron_i), .irq_o(irq_o)
  );

  typedef struct {
    logic [31:0] exp;
    bit          chk;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: plain per-core word arrays and flags
  logic [31:0] m_word [NC][W];
  bit          m_fresh [NC];
  bit          m_ovr [NC];
  int          m_cnt [NC];
  logic [2:0]  m_ctrl [NC];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endfunction

  function automatic logic [31:0] a_word(input int c, input int k);
    return BASE + 32'(c) * STRIDE + 32'(4 * k);
  endfunction

  function automatic logic [31:0] slice_word(input int c, input int k);
    logic [NC*NN-1:0] v;
    v = spike_neuron_i;
    return v[c*NN + NN-1 - 32*k -: 32];
  endfunction

  task automatic set_word(input int c, input int k, input logic [31:0] val);
    spike_neuron_i[c*NN + NN-1 - 32*k -: 32] = val;
  endtask

  always @(negedge wb_clk_i) begin : monitor
    exp_t e;
    if (wbs_ack_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: ack seen with no access outstanding");
      end else begin
        e = sb_q.pop_front();
        if (e.chk) check(e.name, wbs_dat_o, e.exp);
      end
    end
  end

  // One bus access and/or capture, issued right after a negedge
  task automatic op(input bit do_bus, input bit we, input logic [31:0] adr, input logic [3:0] sel,
                    input logic [31:0] dat, input logic [NC-1:0] cap, input string name);
    logic [31:0] exp_rd, off;
    bit          old_fresh [NC];
    logic [2:0]  old_ctrl [NC];
    bit          mapped;
    int          c, i;
    exp_t        e;
    for (int j = 0; j < NC; j++) begin
      old_fresh[j] = m_fresh[j];
      old_ctrl[j]  = m_ctrl[j];
    end
    exp_rd = 0; mapped = 0; c = 0; i = 0;
    if (do_bus) begin
      off = adr - BASE;
      if (adr >= BASE) begin
        c = int'(off / STRIDE);
        i = int'((off % STRIDE) / 4);
        mapped = (c < NC) && (i < W + 2);
      end
      if (mapped) begin
        if (i < W) begin
          exp_rd = m_word[c][i];
          if (!we && old_ctrl[c][1]) m_word[c][i] = 0;
          if (we && !cap[c])
            for (int b = 0; b < 4; b++)
              if (sel[b]) m_word[c][i][8*b +: 8] = dat[8*b +: 8];
        end else if (i == W) begin
          exp_rd = {16'(m_cnt[c]), 14'd0, m_ovr[c], m_fresh[c]};
          if (we && sel[0]) begin
            if (dat[0]) m_fresh[c] = 0;
            if (dat[1]) m_ovr[c] = 0;
          end
        end else begin
          exp_rd = {29'd0, m_ctrl[c]};
          if (we && sel[0]) m_ctrl[c] = dat[2:0];
        end
      end
      e.exp = exp_rd; e.chk = !we; e.name = name;
      sb_q.push_back(e);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
      wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat;
    end
    for (int j = 0; j < NC; j++) begin
      if (cap[j]) begin
        for (int k = 0; k < W; k++)
          m_word[j][k] = slice_word(j, k) | (old_ctrl[j][0] ? m_word[j][k] : 32'd0);
        if (old_fresh[j]) m_ovr[j] = 1;
        m_fresh[j] = 1;
        if (m_cnt[j] < 65535) m_cnt[j]++;
      end
    end
    enable_calc_i = cap;
    @(negedge wb_clk_i);
    enable_calc_i = '0;
    if (do_bus) begin
      check({name, "_ack"}, 32'(wbs_ack_o), 32'd1);
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      @(negedge wb_clk_i);
      check({name, "_ack_low"}, 32'(wbs_ack_o), 32'd0);
    end
  endtask

  task automatic rd(input logic [31:0] adr, input string name);
    op(1, 0, adr, 4'hF, 32'd0, '0, name);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat, input string name);
    op(1, 1, adr, sel, dat, '0, name);
  endtask

  task automatic cap(input logic [NC-1:0] v);
    op(0, 0, 32'd0, 4'h0, 32'd0, v, "cap");
  endtask

  task automatic check_irq(input string name);
    logic [NC-1:0] exp_irq;
    repeat (2) @(negedge wb_clk_i);
    for (int c = 0; c < NC; c++) exp_irq[c] = m_fresh[c] & m_ctrl[c][2];
    check(name, 32'(irq_o), 32'(exp_irq));
  endtask

  initial begin
    logic [NC-1:0] rcap;
    logic [31:0]   adr;
    int            c, kind;
    for (int j = 0; j < NC; j++) begin
      for (int k = 0; k < W; k++) m_word[j][k] = 0;
      m_fresh[j] = 0; m_ovr[j] = 0; m_cnt[j] = 0; m_ctrl[j] = 0;
    end
    wb_rst_i = 1; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    enable_calc_i = '0; spike_neuron_i = '0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 0;
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);

    rd(a_word(0, 0), "c0_w0_rst");
    rd(a_word(1, W), "c1_status_rst");

    set_word(1, 0, 32'hDEADBEEF);
    cap(2'b10);
    rd(32'h80050000, "c1_w0_capture");
    rd(a_word(1, W), "c1_status_capture");
    check_irq("irq_disabled");

    spike_neuron_i = '0;
    wr(a_word(0, W + 1), 4'hF, 32'd1, "c0_ctrl_acc");
    set_word(0, 0, 32'h0000000F);
    cap(2'b01);
    set_word(0, 0, 32'h000000F0);
    cap(2'b01);
    rd(a_word(0, 0), "c0_w0_accum");
    rd(a_word(0, W), "c0_status_overrun");
    wr(a_word(0, W), 4'h1, 32'h3, "c0_w1c");
    rd(a_word(0, W), "c0_status_w1c");

    wr(a_word(0, W + 1), 4'hF, 32'd2, "c0_ctrl_cor");
    set_word(0, 0, 32'h12345678);
    cap(2'b01);
    rd(a_word(0, 0), "c0_cor_first");
    rd(a_word(0, 0), "c0_cor_second");

    wr(a_word(0, 0), 4'b0010, 32'hAABBCCDD, "c0_w0_bytewr");
    rd(a_word(0, 0), "c0_w0_byte");
    rd(a_word(0, W + 2), "unmapped_idx");
    rd(32'h80030000, "unmapped_below");

    wr(a_word(0, W), 4'h1, 32'h3, "c0_w1c_pre_irq");
    wr(a_word(0, W + 1), 4'hF, 32'd4, "c0_ctrl_irqen");
    check_irq("irq_idle");
    set_word(0, 0, 32'h55AA55AA);
    op(1, 1, a_word(0, 0), 4'hF, 32'hFFFFFFFF, 2'b01, "cap_vs_write");
    check_irq("irq_set");
    rd(a_word(0, 0), "c0_w0_cap_wins");
    wr(a_word(0, W), 4'h1, 32'h1, "c0_w1c_irq");
    check_irq("irq_clear");

    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j < NC * NN / 32; j++) spike_neuron_i[32*j +: 32] = $urandom();
      for (int j = 0; j < NC; j++) rcap[j] = ($urandom_range(0, 2) == 0);
      c = $urandom_range(0, NC - 1);
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1:    adr = a_word(c, $urandom_range(0, W - 1));
        2, 3:    adr = a_word(c, W);
        4, 5:    adr = a_word(c, W + 1);
        6: begin
          case ($urandom_range(0, 2))
            0:       adr = BASE - 32'd4;
            1:       adr = a_word(NC, $urandom_range(0, W + 1));
            default: adr = a_word(c, W + 2 + $urandom_range(0, 7));
          endcase
        end
        default: adr = 32'd0;
      endcase
      if (kind == 3 || kind == 5) rcap[c] = 0;
      if (kind == 7) op(0, 0, 32'd0, 4'h0, 32'd0, rcap, "rnd_cap");
      else op(1, (kind % 2 == 1), adr, 4'($urandom_range(0, 15)), $urandom(), rcap,
              $sformatf("rnd%0d_k%0d", n, kind));
      if (n % 20 == 19) check_irq($sformatf("rnd%0d_irq", n));
    end

    repeat (4) @(negedge wb_clk_i);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
